// File: rtl/dmux8way16_seq_if.sv
// Bus bundle for dmux8way16_seq: producer-side word/steering signals plus
// the eight registered channel outputs with their per-channel handshake.
interface dmux8way16_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic             x_ready;
  logic [2:0]       sel;
  logic             auto;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]       y_valid;
  logic [7:0]       y_ready;
  logic [2:0]       ptr;

  // master = producer/consumer side, slave = the demultiplexer
  modport master (
    output x, x_valid, sel, auto, y_ready,
    input  x_ready, a, b, c, d, e, f, g, h, y_valid, ptr
  );

  modport slave (
    input  x, x_valid, sel, auto, y_ready,
    output x_ready, a, b, c, d, e, f, g, h, y_valid, ptr
  );
endinterface

// File: rtl/dmux8way16_seq.sv
// Registered 1-to-8 demultiplexer with per-channel valid/ready, one word deep.
// Round-robin steering via `auto` is compiled in only when DMUX8WAY16_SEQ_AUTO_EN is defined.
module dmux8way16_seq #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  dmux8way16_seq_if.slave bus
);

`ifdef DMUX8WAY16_SEQ_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [7:0]       valid_q, valid_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             use_ptr;
  logic [2:0]       tgt;
  logic             accept;

  assign use_ptr     = AUTO_EN && bus.auto;
  assign tgt         = use_ptr ? ptr_q : bus.sel;
  // A full target still accepts when its consumer drains in the same cycle.
  assign bus.x_ready = ~valid_q[tgt] | bus.y_ready[tgt];
  assign accept      = bus.x_valid & bus.x_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    valid_d = valid_q & ~bus.y_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (accept) begin
      data_d[tgt]  = bus.x;
      valid_d[tgt] = 1'b1;
      if (use_ptr) ptr_d = ptr_q + 3'd1;
    end
  end

  // NOTE: the channel registers are visible outputs, so unlike a plain storage array they are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all state updates see pre-edge values.
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.a       = data_q[0];
  assign bus.b       = data_q[1];
  assign bus.c       = data_q[2];
  assign bus.d       = data_q[3];
  assign bus.e       = data_q[4];
  assign bus.f       = data_q[5];
  assign bus.g       = data_q[6];
  assign bus.h       = data_q[7];
  assign bus.y_valid = valid_q;
  assign bus.ptr     = AUTO_EN ? ptr_q : 3'd0;

endmodule

// File: tb/tb_dmux8way16_seq.sv
// Self-checking bench for dmux8way16_seq: directed vector table, hand-written
// corner sequences and a randomized run against a per-channel reference model.
module tb_dmux8way16_seq;

`ifdef DMUX8WAY16_SEQ_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  dmux8way16_seq_if #(.WIDTH(16)) bus ();

  dmux8way16_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: what each channel holds, whether it is full, and the pointer.
  logic [15:0] m_data [8];
  logic [7:0]  m_valid;
  int          m_ptr;

  typedef struct {
    logic [15:0] x;
    logic [2:0]  sel;
    logic [7:0]  exp_yv;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_ch(input int i);
    case (i)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      3:       return bus.d;
      4:       return bus.e;
      5:       return bus.f;
      6:       return bus.g;
      default: return bus.h;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_data[i] = 16'h0;
    m_valid = 8'h00;
    m_ptr   = 0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s ch%0d", tag, i), 32'(get_ch(i)), 32'(m_data[i]));
    check({tag, " y_valid"}, 32'(bus.y_valid), 32'(m_valid));
    check({tag, " ptr"}, 32'(bus.ptr), 32'(m_ptr));
  endtask

  // One clock: predict x_ready, clock the DUT, advance the model, compare the state.
  task automatic step(input string tag);
    int t;
    bit rdy, acc, rr;
    #1;
    rr  = AUTO_EN && bus.auto;
    t   = rr ? m_ptr : int'(bus.sel);
    rdy = !m_valid[t] || bus.y_ready[t];
    acc = bus.x_valid && rdy;
    check({tag, " x_ready"}, 32'(bus.x_ready), 32'(rdy));
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && bus.y_ready[i]) m_valid[i] = 1'b0;
    if (acc) begin
      m_data[t]  = bus.x;
      m_valid[t] = 1'b1;
      if (rr) m_ptr = (m_ptr + 1) % 8;
    end
    #1;
    check_state(tag);
  endtask

  task automatic drive(input logic [15:0] x, input logic xv, input logic [2:0] sel,
                       input logic au, input logic [7:0] yr);
    bus.x       = x;
    bus.x_valid = xv;
    bus.sel     = sel;
    bus.auto    = au;
    bus.y_ready = yr;
  endtask

  task automatic hard_reset();
    drive(16'h0, 1'b0, 3'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cum;
    rst = 1'b1;
    drive(16'h0, 1'b0, 3'd0, 1'b0, 8'h00);
    model_reset();
    #3;
    check_state("power-on reset");
    check("power-on x_ready", 32'(bus.x_ready), 32'd1);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed steering: one word per channel, no drains, back-to-back.
    cum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cum       = cum | (8'h01 << i);
      vecs[i].x      = 16'(16'h1111 * (i + 1));
      vecs[i].sel    = 3'(i);
      vecs[i].exp_yv = cum;
    end
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].x, 1'b1, vecs[i].sel, 1'b0, 8'h00);
      step($sformatf("steer%0d", i));
      check($sformatf("steer%0d yv", i), 32'(bus.y_valid), 32'(vecs[i].exp_yv));
      check($sformatf("steer%0d data", i), 32'(get_ch(i)), 32'(vecs[i].x));
    end
    check("steer all full", 32'(bus.y_valid), 32'hFF);
    check("steer h", 32'(bus.h), 32'h8888);

    // Drain every channel except d, then back-pressure d only.
    drive(16'h0, 1'b0, 3'd0, 1'b0, 8'hF7);
    step("drain7");
    check("drain7 yv", 32'(bus.y_valid), 32'h08);
    drive(16'hDEAD, 1'b1, 3'd3, 1'b0, 8'h00);
    step("bp d");
    check("bp d ready", 32'(bus.x_ready), 32'd0);
    check("bp d held", 32'(bus.d), 32'h4444);
    drive(16'hDEAD, 1'b1, 3'd5, 1'b0, 8'h00);
    step("bp f");
    check("bp f loaded", 32'(bus.f), 32'hDEAD);

    // Simultaneous drain and load on d, twice back-to-back.
    drive(16'hAAAA, 1'b1, 3'd3, 1'b0, 8'h08);
    step("dl1");
    check("dl1 d", 32'(bus.d), 32'hAAAA);
    drive(16'hBBBB, 1'b1, 3'd3, 1'b0, 8'h08);
    step("dl2");
    check("dl2 d", 32'(bus.d), 32'hBBBB);
    check("dl2 yv3", 32'(bus.y_valid[3]), 32'd1);

    // Build y_valid = 8'h5A, then reset asynchronously between edges.
    drive(16'h0, 1'b0, 3'd0, 1'b0, 8'hFF);
    step("clr");
    for (int i = 0; i < 8; i++) begin
      if (8'h5A & (8'h01 << i)) begin
        drive(16'(16'h0F00 + i), 1'b1, 3'(i), 1'b0, 8'h00);
        step($sformatf("fill%0d", i));
      end
    end
    drive(16'h0, 1'b0, 3'd0, 1'b0, 8'h00);
    check("pre-rst yv", 32'(bus.y_valid), 32'h5A);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state("mid reset");
    check("mid reset x_ready", 32'(bus.x_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef DMUX8WAY16_SEQ_AUTO_EN
    // Round-robin: ten words with every consumer draining.
    for (int i = 0; i < 10; i++) begin
      drive(16'(i), 1'b1, 3'd7, 1'b1, 8'hFF);
      step($sformatf("rr%0d", i));
    end
    check("rr ptr", 32'(bus.ptr), 32'd2);
    check("rr a", 32'(bus.a), 32'd8);
    check("rr b", 32'(bus.b), 32'd9);

    // Round-robin stall with ptr=4 and channel e full.
    hard_reset();
    for (int i = 0; i < 4; i++) begin
      drive(16'(16'h0C00 + i), 1'b1, 3'd0, 1'b1, 8'h00);
      step($sformatf("rrs%0d", i));
    end
    drive(16'h0E0E, 1'b1, 3'd4, 1'b0, 8'h00);
    step("rrs load e");
    check("rrs ptr before", 32'(bus.ptr), 32'd4);
    drive(16'h5555, 1'b1, 3'd0, 1'b1, 8'h00);
    step("rrs stall");
    check("rrs stall ready", 32'(bus.x_ready), 32'd0);
    check("rrs ptr held", 32'(bus.ptr), 32'd4);
`else
    // Without round-robin, auto is ignored and ptr stays 0.
    drive(16'h1234, 1'b1, 3'd6, 1'b1, 8'h00);
    step("noauto");
    check("noauto g", 32'(bus.g), 32'h1234);
    check("noauto ptr", 32'(bus.ptr), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(16'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom), 8'($urandom));
      step($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmux8way16_seq.md
# dmux8way16_seq

Registered 1-to-8 demultiplexer for 16-bit words: the receiving-side counterpart of the 8-way 16-bit multiplexer. One input word per cycle is steered by `sel` (or by an internal round-robin pointer) into one of eight single-entry output registers `a`..`h`. Each output has its own valid/ready handshake, so a stalled consumer back-pressures only words addressed to it.

## Interface
- `WIDTH`, 16: data width of the input and of every output.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `x`  in  WIDTH  input data word.
- `x_valid`  in  1  input word present.
- `x_ready`  out  1  input accepted this cycle when high together with `x_valid`.
- `sel`  in  3  target channel, 0=`a` … 7=`h`; used when `auto`=0.
- `auto`  in  1  round-robin steering enable; see Configuration.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  out  WIDTH  channel output registers.
- `y_valid`  out  8  bit i high = channel i holds an undelivered word.
- `y_ready`  in  8  bit i high = consumer i takes its word this cycle.
- `ptr`  out  3  current round-robin pointer.

## Operation
- Target channel t = `ptr` when `auto`=1 (macro defined), else `sel`.
- Accept = `x_valid` & `x_ready`; `x_ready` = ~`y_valid[t]` | `y_ready[t]`. This is a combinational path from `sel`, `auto` and `y_ready` to `x_ready`.
- On accept: channel t register <= `x`, `y_valid[t]` <= 1.
- Drain: for each i, if `y_valid[i]` & `y_ready[i]` and channel i is not loaded this cycle, `y_valid[i]` <= 0.
- Same-cycle drain and load on channel t: the new word replaces the old one and `y_valid[t]` stays 1. There is no bubble.
- Drains on channels other than t proceed independently in the same cycle. All eight channels may drain at once.
- Output registers hold their last value after draining. They change only on load or reset.
- `ptr`: increments by 1 on each accept while `auto`=1, wrapping 7 -> 0. It holds when `auto`=0 or when there is no accept. Toggling `auto` does not reset `ptr`.
- `x_valid`=1 with `x_ready`=0: no state change. The producer must hold `x` and `sel` stable until accepted.
- `sel` and `auto` are sampled only in the accept cycle.

## Timing
- Reset (asynchronous, immediate): `a`..`h` = 0, `y_valid` = 8'h00, `ptr` = 0.
- `x_ready` after reset: 1, because all channels are empty.
- Reset mid-operation discards all stored words. Any handshake in the reset cycle is lost.
- Latency: a word accepted at edge n is visible on its channel, with its valid bit high, after edge n.
- Throughput: 1 word/cycle sustained when the target consumer drains every cycle.
- Throughput: 1 word/cycle across distinct channels regardless of drains, until those channels fill.
- Per-channel depth: 1. A full channel with `y_ready` low stalls only inputs addressed to that channel.

## Configuration
- `DMUX8WAY16_SEQ_AUTO_EN` defined: round-robin mode is compiled in. `auto` selects `ptr`-based steering and `ptr` counts as described above.
- `DMUX8WAY16_SEQ_AUTO_EN` undefined: the `auto` port exists but is ignored, t = `sel` always, and `ptr` is tied to 0.
- The handshake and data path are identical in both builds.

## Test plan
- Reset check: assert `rst` mid-run with `y_valid`=8'h5A -> `y_valid`=8'h00, `a`..`h`=0 and `ptr`=0 immediately, before the next edge; `x_ready`=1.
- Directed steering: `auto`=0, `y_ready`=8'h00, send 16'h1111 to `sel`=0 through 16'h8888 to `sel`=7, one per cycle -> all accepted back-to-back, `a`=16'h1111 … `h`=16'h8888, `y_valid`=8'hFF.
- Back-pressure on one channel: `y_valid[3]`=1, `y_ready[3]`=0, `sel`=3, `x_valid`=1 -> `x_ready`=0 and `d` unchanged. Switch `sel` to 5 -> accepted, `f` loaded.
- Simultaneous drain and load: `d`=16'hAAAA valid, `y_ready[3]`=1, accept 16'hBBBB to `sel`=3 in the same cycle -> `d`=16'hBBBB, `y_valid[3]` stays 1, no idle cycle.
- Round-robin (macro defined): `auto`=1, `y_ready`=8'hFF, 10 accepted words 0..9 -> channels 0..7 then 0 and 1; final `ptr`=2, `a`=8, `b`=9.
- Round-robin stall: `auto`=1, `ptr`=4, `y_valid[4]`=1, `y_ready[4]`=0, `x_valid`=1 -> `x_ready`=0 and `ptr` stays 4.
- Macro undefined: `auto`=1 with `sel`=6 -> word lands in `g`, `ptr` stays 0.
